// File: rtl/sramlike_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI3 bridge.
package sramlike_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;

  localparam logic [1:0]      BURST_INCR = 2'b01;
  localparam logic [ID_W-1:0] ID_INST    = 4'd0;
  localparam logic [ID_W-1:0] ID_DATA    = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_B
  } state_e;

  // Request captured on addr_ok and held for the whole transaction.
  typedef struct packed {
    logic              owner_data;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << addr_lo;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sramlike_axi_bridge.sv
// Arbitrates instruction/data SRAM-like requests onto one AXI3 master,
// one single-beat transaction in flight at a time, data side has priority.
module sramlike_axi_bridge
  import sramlike_axi_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,

  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,

  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,

  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,

  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e state, state_nxt;
  req_t   req_q, req_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;

  // Response ids/status are not needed with a single outstanding transaction.
  logic unused_resp;
  assign unused_resp = &{1'b0, rid, rresp, rlast, bid, bresp};

  assign arlen   = 8'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 8'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  // Channel payloads come straight from the latched request, so they hold under backpressure.
  assign arid   = req_q.owner_data ? ID_DATA : ID_INST;
  assign awid   = arid;
  assign wid    = arid;
  assign araddr = req_q.addr;
  assign awaddr = req_q.addr;
  assign arsize = {1'b0, req_q.size};
  assign awsize = {1'b0, req_q.size};
  assign wdata  = req_q.wdata;
  assign wstrb  = size_to_wstrb(req_q.size, req_q.addr[1:0]);
  assign wlast  = wvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    req_nxt      = req_q;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (data_req) begin
            data_addr_ok = 1'b1;
            req_nxt      = '{owner_data: 1'b1, wr: data_wr, size: data_size,
                             addr: data_addr, wdata: data_wdata};
            state_nxt    = data_wr ? ST_AW : ST_AR;
          end else if (inst_req) begin
            inst_addr_ok = 1'b1;
            req_nxt      = '{owner_data: 1'b0, wr: inst_wr, size: inst_size,
                             addr: inst_addr, wdata: inst_wdata};
            state_nxt    = inst_wr ? ST_AW : ST_AR;
          end
        end
        ST_AR: begin
          arvalid = 1'b1;
          if (arready) state_nxt = ST_R;
        end
        ST_R: begin
          rready = 1'b1;
          if (rvalid) begin
            if (req_q.owner_data) begin
              data_data_ok = 1'b1;
              data_rdata   = rdata;
            end else begin
              inst_data_ok = 1'b1;
              inst_rdata   = rdata;
            end
            state_nxt = ST_IDLE;
          end
        end
        ST_AW: begin
          awvalid = !aw_done;
          wvalid  = !w_done;
          if (awready) aw_done_nxt = 1'b1;
          if (wready)  w_done_nxt  = 1'b1;
          if ((aw_done || awready) && (w_done || wready)) state_nxt = ST_B;
        end
        ST_B: begin
          bready = 1'b1;
          if (bvalid) begin
            data_data_ok = req_q.owner_data;
            inst_data_ok = !req_q.owner_data;
            state_nxt    = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench: vector table of single transactions plus hand-written
// contention, split-handshake, backpressure and reset sequences.
module tb_sramlike_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sramlike_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        side;   // 1 = data port, 0 = instruction port
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [3:0]  strb;
    int          rdly;
  } vec_t;

  typedef struct {
    logic        side;
    logic        wr;
    logic [31:0] rdat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  function automatic logic [8:0] ctrl_outs();
    return {arvalid, rready, awvalid, wvalid, bready,
            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
  endfunction

  task automatic drive_req(input logic side, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd);
    if (side) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
  endtask

  // Scoreboard: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (inst_data_ok || data_data_ok) begin
      chk_b("data_ok_exclusive", inst_data_ok & data_data_ok, 1'b0);
      chk_b("ok_overlap", inst_addr_ok | data_addr_ok, 1'b0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_data_ok: got inst=%b data=%b, expected none", inst_data_ok, data_data_ok);
      end else begin
        e = sb.pop_front();
        chk_b("resp_side", data_data_ok, e.side);
        if (!e.wr) chk("rdata", e.side ? data_rdata : inst_rdata, e.rdat);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    @(negedge clk);
    drive_req(v.side, v.wr, v.size, v.addr, v.wdat);
    #1;
    chk_b("addr_ok", v.side ? data_addr_ok : inst_addr_ok, 1'b1);
    chk_b("other_addr_ok", v.side ? inst_addr_ok : data_addr_ok, 1'b0);
    sb.push_back('{side: v.side, wr: v.wr, rdat: v.rdat});
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b0;
    #1;
    if (!v.wr) begin
      chk_b("arvalid", arvalid, 1'b1);
      chk("arid", 32'(arid), 32'(v.side));
      chk("araddr", araddr, v.addr);
      chk("arsize", 32'(arsize), 32'(v.size));
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < v.rdly; i++) begin
        #1 chk_b("rready_wait", rready, 1'b1);
        @(negedge clk);
      end
      rvalid = 1'b1; rdata = v.rdat;
      @(negedge clk);
      rvalid = 1'b0; rdata = 32'h0;
    end else begin
      chk_b("awvalid", awvalid, 1'b1);
      chk_b("wvalid", wvalid, 1'b1);
      chk("awaddr", awaddr, v.addr);
      chk("awsize", 32'(awsize), 32'(v.size));
      chk("awid", 32'(awid), 32'(v.side));
      chk("wid", 32'(wid), 32'(v.side));
      chk("wdata", wdata, v.wdat);
      chk("wstrb", 32'(wstrb), 32'(v.strb));
      chk_b("wlast", wlast, 1'b1);
      awready = 1'b1; wready = 1'b1;
      @(negedge clk);
      awready = 1'b0; wready = 1'b0;
      #1 chk_b("bready", bready, 1'b1);
      bvalid = 1'b1;
      @(negedge clk);
      bvalid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0,         32'h2408_0001, 4'b1111, 1};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AA, 32'h0,         4'b1000, 0};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h8000_0012, 32'h1234_5678, 32'h0,         4'b1100, 0};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 32'h8000_0020, 32'hDEAD_BEEF, 32'h0,         4'b1111, 0};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'h0,         32'hCAFE_F00D, 4'b1111, 0};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h8000_0050, 32'h0000_BEEF, 32'h0,         4'b0011, 0};
    vecs[6] = '{1'b1, 1'b1, 2'd0, 32'h8000_0061, 32'h0000_5500, 32'h0,         4'b0010, 0};
    vecs[7] = '{1'b0, 1'b0, 2'd1, 32'hBFC0_0006, 32'h0,         32'h0000_1357, 4'b1111, 2};

    rst = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 32'(ctrl_outs()), 32'h0);
    chk("reset_araddr", araddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Contention: data wins, instruction is granted in the IDLE after data_ok.
    @(negedge clk);
    drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0010, 32'h0);
    drive_req(1'b1, 1'b0, 2'd2, 32'h8000_0100, 32'h0);
    #1;
    chk_b("cont_data_addr_ok", data_addr_ok, 1'b1);
    chk_b("cont_inst_addr_ok", inst_addr_ok, 1'b0);
    sb.push_back('{side: 1'b1, wr: 1'b0, rdat: 32'h1111_2222});
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("cont_arid", 32'(arid), 32'd1);
    chk("cont_araddr", araddr, 32'h8000_0100);
    chk_b("cont_inst_wait_ar", inst_addr_ok, 1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
    #1 chk_b("cont_inst_wait_r", inst_addr_ok, 1'b0);
    @(negedge clk);
    rvalid = 1'b0;
    #1 chk_b("cont_inst_grant", inst_addr_ok, 1'b1);
    sb.push_back('{side: 1'b0, wr: 1'b0, rdat: 32'h3333_4444});
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    chk("cont_arid_inst", 32'(arid), 32'd0);
    chk("cont_araddr_inst", araddr, 32'hBFC0_0010);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h3333_4444;
    @(negedge clk);
    rvalid = 1'b0;

    // Split write handshake: AW accepted at T+1, W only at T+4.
    @(negedge clk);
    drive_req(1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'hA5A5_5A5A);
    #1 chk_b("split_addr_ok", data_addr_ok, 1'b1);
    sb.push_back('{side: 1'b1, wr: 1'b1, rdat: 32'h0});
    @(negedge clk);
    data_req = 1'b0;
    #1;
    chk_b("split_awvalid_t1", awvalid, 1'b1);
    chk_b("split_wvalid_t1", wvalid, 1'b1);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    #1;
    chk_b("split_awvalid_t2", awvalid, 1'b0);
    chk_b("split_wvalid_t2", wvalid, 1'b1);
    chk_b("split_bready_t2", bready, 1'b0);
    @(negedge clk);
    #1;
    chk_b("split_wvalid_t3", wvalid, 1'b1);
    chk_b("split_bready_t3", bready, 1'b0);
    @(negedge clk);
    wready = 1'b1;
    #1;
    chk_b("split_wvalid_t4", wvalid, 1'b1);
    chk_b("split_bready_t4", bready, 1'b0);
    @(negedge clk);
    wready = 1'b0;
    #1;
    chk_b("split_bready_t5", bready, 1'b1);
    chk_b("split_wvalid_t5", wvalid, 1'b0);
    chk_b("split_awvalid_t5", awvalid, 1'b0);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0;

    // Backpressure on AR: payload stable and no grants while arready is low.
    @(negedge clk);
    drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0100, 32'h0);
    #1 chk_b("bp_addr_ok", inst_addr_ok, 1'b1);
    sb.push_back('{side: 1'b0, wr: 1'b0, rdat: 32'h0BAD_F00D});
    @(negedge clk);
    inst_req = 1'b0;
    drive_req(1'b1, 1'b0, 2'd2, 32'h8000_2000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_b("bp_arvalid", arvalid, 1'b1);
      chk("bp_araddr", araddr, 32'hBFC0_0100);
      chk("bp_arid", 32'(arid), 32'd0);
      chk_b("bp_no_grant", data_addr_ok | inst_addr_ok, 1'b0);
      @(negedge clk);
    end
    data_req = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    @(negedge clk);
    rvalid = 1'b0;

    // Reset while in R: transaction dropped, late rvalid produces nothing.
    @(negedge clk);
    drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0200, 32'h0);
    #1 chk_b("rst_addr_ok", inst_addr_ok, 1'b1);
    @(negedge clk);
    inst_req = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    #1 chk_b("rst_in_r", rready, 1'b1);
    rst = 1'b1;
    #1 chk("rst_during", 32'(ctrl_outs()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_after_ctrl", 32'(ctrl_outs()), 32'h0);
    chk("rst_after_araddr", araddr, 32'h0);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    #1 chk_b("rst_no_data_ok", inst_data_ok | data_data_ok, 1'b0);
    @(negedge clk);
    rvalid = 1'b0;

    // Bridge still works after reset.
    run_txn(vecs[4]);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
